// File: rtl/lsl33_seq_ctrl_if.sv
// Handshake/data bundle for the LSL33 sequencer.
// master drives start/d_in/amount, slave returns busy/done/d_out.
interface lsl33_seq_ctrl_if #(
  parameter int AMT_W = 6
);
  logic             start;
  logic [32:0]      d_in;
  logic [AMT_W-1:0] amount;
  logic             busy;
  logic             done;
  logic [32:0]      d_out;

  modport master (
    output start, d_in, amount,
    input  busy, done, d_out
  );

  modport slave (
    input  start, d_in, amount,
    output busy, done, d_out
  );
endinterface

// File: rtl/lsl33_seq_ctrl.sv
// Multi-cycle 33-bit logical left shifter, 0..3 bits per SHIFT cycle.
// Ports: clk, reset (async high), bus (slave: start/d_in/amount -> busy/done/d_out).
module lsl33_seq_ctrl #(
  parameter int AMT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  lsl33_seq_ctrl_if.slave  bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [32:0]      work;
  logic [AMT_W-1:0] rem;
  logic [1:0]       step;
  logic [32:0]      shifted;

  always_comb begin
    step = (rem >= AMT_W'(3)) ? 2'd3 : rem[1:0];
  end

  // 4:1 mux per bit: the 0..3-bit shift stage
  always_comb begin
    shifted = work;
    unique case (step)
      2'd0: shifted = work;
      2'd1: shifted = {work[31:0], 1'b0};
      2'd2: shifted = {work[30:0], 2'b0};
      2'd3: shifted = {work[29:0], 3'b0};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      work  <= '0;
      rem   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            work  <= bus.d_in;
            rem   <= bus.amount;
            state <= (bus.amount == '0) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          work <= shifted;
          rem  <= rem - AMT_W'(step);
          if (rem <= AMT_W'(3))
            state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy  = (state != S_IDLE);
  assign bus.done  = (state == S_DONE);
  assign bus.d_out = work;
endmodule

// File: tb/tb_lsl33_seq_ctrl.sv
// Directed scoreboard bench for lsl33_seq_ctrl.
// Expected results are queued on start and checked at done.
module tb_lsl33_seq_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [32:0] val;
    int          lat;
  } exp_t;
  exp_t q[$];

  lsl33_seq_ctrl_if #(.AMT_W(6)) bus ();

  lsl33_seq_ctrl #(.AMT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] lsl_model(input logic [32:0] d, input int amt);
    logic [65:0] t;
    t = {33'b0, d} << amt;
    return t[32:0];
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic job(input logic [32:0] d, input int amt, input bit poke);
    exp_t e;
    int   n;
    e.val = lsl_model(d, amt);
    e.lat = (amt + 2) / 3;
    q.push_back(e);
    bus.start  = 1'b1;
    bus.d_in   = d;
    bus.amount = 6'(amt);
    tick();
    bus.start  = 1'b0;
    bus.d_in   = '0;
    chk("busy_after_accept", 33'(bus.busy), 33'd1);
    n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      if (poke && n == 1) begin
        bus.start  = 1'b1;
        bus.d_in   = 33'h1_FFFF_FFFF;
        bus.amount = 6'd1;
      end
      tick();
      bus.start = 1'b0;
      n++;
    end
    e = q.pop_front();
    if (bus.done !== 1'b1) begin
      chk("done_timeout", 33'(bus.done), 33'd1);
    end else begin
      chk("result", bus.d_out, e.val);
      chk("latency", 33'(n), 33'(e.lat));
    end
    if (poke) begin
      bus.start  = 1'b1;
      bus.d_in   = 33'h1_FFFF_FFFF;
      bus.amount = 6'd2;
    end
    tick();
    bus.start = 1'b0;
    chk("idle_busy", 33'(bus.busy), 33'd0);
    chk("done_one_cycle", 33'(bus.done), 33'd0);
    chk("hold_result", bus.d_out, e.val);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.d_in   = '0;
    bus.amount = '0;
    #1;
    chk("rst_busy", 33'(bus.busy), 33'd0);
    chk("rst_done", 33'(bus.done), 33'd0);
    chk("rst_dout", bus.d_out, 33'd0);
    #20;
    reset = 1'b0;
    tick();

    job(33'h0_0000_0007, 4, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_dout", bus.d_out, 33'd0);
    chk("async_rst_busy", 33'(bus.busy), 33'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_hold", {bus.busy, bus.done, bus.d_out[30:0]}, 33'd0);
    end

    job(33'h0_1234_5678, 0, 1'b0);
    job(33'h0_0000_0001, 5, 1'b0);
    job(33'h0_0000_0001, 32, 1'b0);
    job(33'h1_FFFF_FFFF, 40, 1'b0);
    job(33'h0_0000_0003, 9, 1'b1);
    job(33'h1_FFFF_FFFF, 1, 1'b0);
    job(33'h0_0F0F_0F0F, 63, 1'b0);
    job(33'h1_2345_6789, 31, 1'b0);
    job({1'b0, $urandom()}, 7, 1'b0);

    bus.start  = 1'b1;
    bus.d_in   = 33'h0_0000_0001;
    bus.amount = 6'd30;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("abort_dout", bus.d_out, 33'd0);
    chk("abort_busy", 33'(bus.busy), 33'd0);
    chk("abort_done", 33'(bus.done), 33'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("no_done_after_abort", 33'(bus.done), 33'd0);
    end
    job(33'h0_0000_0001, 3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
